// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM for the multicycle MIPS core
module multicycle_controller #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q, state_d;

  // Raw control values before reset gating
  logic       c_mem_req, c_memwrite, c_iord, c_irwrite, c_pcen;
  logic [1:0] c_pcsrc;
  logic       c_regdst, c_memtoreg, c_regwrite, c_alusrca;
  logic [1:0] c_alusrcb;
  logic [2:0] c_alucontrol;
  logic       c_illegal;

  // State register; reset returns to FETCH immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and control decode for the current step
  always_comb begin
    state_d      = state_q;
    c_mem_req    = 1'b0;
    c_memwrite   = 1'b0;
    c_iord       = 1'b0;
    c_irwrite    = 1'b0;
    c_pcen       = 1'b0;
    c_pcsrc      = 2'b00;
    c_regdst     = 1'b0;
    c_memtoreg   = 1'b0;
    c_regwrite   = 1'b0;
    c_alusrca    = 1'b0;
    c_alusrcb    = 2'b00;
    c_alucontrol = 3'b000;
    c_illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 is computed every cycle; it is only committed when the fetch completes
        c_mem_req    = 1'b1;
        c_alusrcb    = 2'b01;
        c_alucontrol = ALU_ADD;
        if (mem_ready) begin
          c_irwrite = 1'b1;
          c_pcen    = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is speculatively computed into ALUOut
        c_alusrcb    = 2'b11;
        c_alucontrol = ALU_ADD;
        if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
        else if (op == OP_RTYPE)        state_d = S_EXEC;
        else if (op == OP_BEQ)          state_d = S_BRANCH;
        else if (op == OP_ADDI)         state_d = S_ADDIEX;
        else if (op == OP_J)            state_d = S_JUMP;
        else begin
          c_illegal = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_MEMADR: begin
        c_alusrca    = 1'b1;
        c_alusrcb    = 2'b10;
        c_alucontrol = ALU_ADD;
        state_d      = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        c_mem_req = 1'b1;
        c_iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        c_regwrite = 1'b1;
        c_memtoreg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        c_mem_req  = 1'b1;
        c_memwrite = 1'b1;
        c_iord     = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        c_alusrca = 1'b1;
        state_d   = S_ALUWB;
        case (funct)
          6'b100000: c_alucontrol = ALU_ADD;
          6'b100010: c_alucontrol = ALU_SUB;
          6'b100100: c_alucontrol = ALU_AND;
          6'b100101: c_alucontrol = ALU_OR;
          6'b101010: c_alucontrol = ALU_SLT;
          default: begin
            c_illegal = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        c_regwrite = 1'b1;
        c_regdst   = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        c_alusrca    = 1'b1;
        c_alucontrol = ALU_SUB;
        c_pcsrc      = 2'b01;
        c_pcen       = zero;
        state_d      = S_FETCH;
      end
      S_ADDIEX: begin
        c_alusrca    = 1'b1;
        c_alusrcb    = 2'b10;
        c_alucontrol = ALU_ADD;
        state_d      = S_ADDIWB;
      end
      S_ADDIWB: begin
        c_regwrite = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        c_pcsrc = 2'b10;
        c_pcen  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // While reset is low every output is held at zero, so an in-flight request drops at once
  assign mem_req    = reset & c_mem_req;
  assign memwrite   = reset & c_memwrite;
  assign iord       = reset & c_iord;
  assign irwrite    = reset & c_irwrite;
  assign pcen       = reset & c_pcen;
  assign pcsrc      = reset ? c_pcsrc : 2'b00;
  assign regdst     = reset & c_regdst;
  assign memtoreg   = reset & c_memtoreg;
  assign regwrite   = reset & c_regwrite;
  assign alusrca    = reset & c_alusrca;
  assign alusrcb    = reset ? c_alusrcb : 2'b00;
  assign alucontrol = reset ? c_alucontrol : 3'b000;
  assign illegal    = reset & c_illegal;
  assign state      = reset ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - table-driven bench for multicycle_controller
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, memwrite, iord, irwrite, pcen;
  logic [1:0] pcsrc;
  logic       regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .pcen(pcen),
    .pcsrc(pcsrc), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [20:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  wire [20:0] act = {mem_req, memwrite, iord, irwrite, pcen, pcsrc, regdst, memtoreg,
                     regwrite, alusrca, alusrcb, alucontrol, illegal, state};

  // {mem_req,memwrite,iord,irwrite,pcen,pcsrc,regdst,memtoreg,regwrite,alusrca,alusrcb,alucontrol,illegal,state}
  function automatic logic [20:0] mk(input logic mreq, input logic mw, input logic io,
                                     input logic irw, input logic pce, input logic [1:0] ps,
                                     input logic rd, input logic m2r, input logic rw,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [2:0] ac, input logic ill, input logic [3:0] st);
    return {mreq, mw, io, irw, pce, ps, rd, m2r, rw, asa, asb, ac, ill, st};
  endfunction

  task automatic check(input string name, input logic [20:0] got, input logic [20:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  task automatic add(input string name, input logic rdy, input logic [5:0] o,
                     input logic [5:0] f, input logic z, input logic [20:0] e);
    vec_t v;
    v.rdy = rdy; v.op = o; v.funct = f; v.zero = z; v.exp = e; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    mem_ready = v.rdy; op = v.op; funct = v.funct; zero = v.zero;
    #2;
    check(v.name, act, v.exp);
  endtask

  logic [20:0] e_fwait, e_fgo, e_dec, e_dec_ill, e_madr, e_mrd, e_mwb, e_mwr;
  logic [20:0] e_ex_slt, e_ex_ill, e_awb, e_br_t, e_br_n, e_aex, e_awb_i, e_jmp;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010, RT = 6'b000000, BAD = 6'b111111;

  initial begin
    e_fwait   = mk(1,0,0,0,0,2'b00,0,0,0,0,2'b01,3'b010,0,4'd0);
    e_fgo     = mk(1,0,0,1,1,2'b00,0,0,0,0,2'b01,3'b010,0,4'd0);
    e_dec     = mk(0,0,0,0,0,2'b00,0,0,0,0,2'b11,3'b010,0,4'd1);
    e_dec_ill = mk(0,0,0,0,0,2'b00,0,0,0,0,2'b11,3'b010,1,4'd1);
    e_madr    = mk(0,0,0,0,0,2'b00,0,0,0,1,2'b10,3'b010,0,4'd2);
    e_mrd     = mk(1,0,1,0,0,2'b00,0,0,0,0,2'b00,3'b000,0,4'd3);
    e_mwb     = mk(0,0,0,0,0,2'b00,0,1,1,0,2'b00,3'b000,0,4'd4);
    e_mwr     = mk(1,1,1,0,0,2'b00,0,0,0,0,2'b00,3'b000,0,4'd5);
    e_ex_slt  = mk(0,0,0,0,0,2'b00,0,0,0,1,2'b00,3'b111,0,4'd6);
    e_ex_ill  = mk(0,0,0,0,0,2'b00,0,0,0,1,2'b00,3'b000,1,4'd6);
    e_awb     = mk(0,0,0,0,0,2'b00,1,0,1,0,2'b00,3'b000,0,4'd7);
    e_br_t    = mk(0,0,0,0,1,2'b01,0,0,0,1,2'b00,3'b110,0,4'd8);
    e_br_n    = mk(0,0,0,0,0,2'b01,0,0,0,1,2'b00,3'b110,0,4'd8);
    e_aex     = mk(0,0,0,0,0,2'b00,0,0,0,1,2'b10,3'b010,0,4'd9);
    e_awb_i   = mk(0,0,0,0,0,2'b00,0,0,1,0,2'b00,3'b000,0,4'd10);
    e_jmp     = mk(0,0,0,0,1,2'b10,0,0,0,0,2'b00,3'b000,0,4'd11);

    // lw with two wait cycles in MEMRD
    add("lw_fetch", 1, LW, 6'd0, 0, e_fgo);
    add("lw_dec",   1, LW, 6'd0, 0, e_dec);
    add("lw_madr",  1, LW, 6'd0, 0, e_madr);
    add("lw_rd0",   0, LW, 6'd0, 0, e_mrd);
    add("lw_rd1",   0, LW, 6'd0, 0, e_mrd);
    add("lw_rd2",   1, LW, 6'd0, 0, e_mrd);
    add("lw_wb",    1, LW, 6'd0, 0, e_mwb);
    // R-type slt, then unsupported funct
    add("slt_fetch", 1, RT, 6'b101010, 0, e_fgo);
    add("slt_dec",   1, RT, 6'b101010, 0, e_dec);
    add("slt_exec",  1, RT, 6'b101010, 0, e_ex_slt);
    add("slt_wb",    1, RT, 6'b101010, 0, e_awb);
    add("badf_fetch",1, RT, 6'b111111, 0, e_fgo);
    add("badf_dec",  1, RT, 6'b111111, 0, e_dec);
    add("badf_exec", 1, RT, 6'b111111, 0, e_ex_ill);
    // beq taken then not taken
    add("beqt_fetch", 1, BEQ, 6'd0, 1, e_fgo);
    add("beqt_dec",   1, BEQ, 6'd0, 1, e_dec);
    add("beqt_br",    1, BEQ, 6'd0, 1, e_br_t);
    add("beqn_fetch", 1, BEQ, 6'd0, 0, e_fgo);
    add("beqn_dec",   1, BEQ, 6'd0, 0, e_dec);
    add("beqn_br",    1, BEQ, 6'd0, 0, e_br_n);
    // sw with one wait cycle, then illegal opcode
    add("sw_fetch", 1, SW, 6'd0, 0, e_fgo);
    add("sw_dec",   1, SW, 6'd0, 0, e_dec);
    add("sw_madr",  1, SW, 6'd0, 0, e_madr);
    add("sw_wr0",   0, SW, 6'd0, 0, e_mwr);
    add("sw_wr1",   1, SW, 6'd0, 0, e_mwr);
    add("badop_fetch", 1, BAD, 6'd0, 0, e_fgo);
    add("badop_dec",   1, BAD, 6'd0, 0, e_dec_ill);
    // addi and jump, fetch stalls once before the jump
    add("addi_fetch", 1, ADDI, 6'd0, 0, e_fgo);
    add("addi_dec",   1, ADDI, 6'd0, 0, e_dec);
    add("addi_ex",    1, ADDI, 6'd0, 0, e_aex);
    add("addi_wb",    1, ADDI, 6'd0, 0, e_awb_i);
    add("j_fwait",    0, JMP, 6'd0, 0, e_fwait);
    add("j_fetch",    1, JMP, 6'd0, 0, e_fgo);
    add("j_dec",      1, JMP, 6'd0, 0, e_dec);
    add("j_jump",     1, JMP, 6'd0, 0, e_jmp);

    // Reset held for three cycles: all outputs zero
    reset = 1'b0; mem_ready = 1'b1; op = LW; funct = 6'd0; zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      check("reset_outputs_zero", act, 21'd0);
    end
    // Release: FETCH requests immediately; hold with mem_ready low so the table starts in FETCH
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0;
    #2;
    check("reset_release_fetch", act, e_fwait);

    foreach (tbl[i]) apply(tbl[i]);

    // Reset during a stalled fetch drops the request without waiting for a clock
    @(negedge clk);
    mem_ready = 1'b0; op = JMP; funct = 6'd0; zero = 1'b0;
    #2;
    check("rst6_pre", act, e_fwait);
    #1 reset = 1'b0;
    #1 check("rst6_async_drop", act, 21'd0);
    @(negedge clk); #2;
    check("rst6_held", act, 21'd0);
    @(negedge clk);
    reset = 1'b1;
    #2;
    check("rst6_restart", act, e_fwait);
    begin
      vec_t v;
      v.rdy = 1; v.op = JMP; v.funct = 6'd0; v.zero = 0; v.exp = e_fgo;  v.name = "rst6_fetch";
      apply(v);
      v.exp = e_dec; v.name = "rst6_dec";
      apply(v);
      v.exp = e_jmp; v.name = "rst6_jump";
      apply(v);
      v.exp = e_fgo; v.name = "rst6_next_fetch";
      apply(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
